// File: rtl/issue_latch_pkg.sv
// Shared types for the issue path: execution entry layout, unit/mode encodings,
// tag widths and the default divider occupancy.
package issue_latch_pkg;

    localparam int TAG_W               = 6;
    localparam int SPECTAG_W           = 4;
    localparam int DIV_LATENCY_DEFAULT = 16;

    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [SPECTAG_W-1:0] spectag_t;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_DIV = 2'd2,
        UNIT_LSU = 2'd3
    } unit_t;

    typedef enum logic {
        EX_NORMAL   = 1'b0,
        EX_GEN_ADDR = 1'b1
    } ex_mode_t;

    typedef struct packed {
        logic        is_valid;
        tag_t        tag;
        unit_t       exec_unit;
        ex_mode_t    mode;
        spectag_t    speculative_tag;
        logic [31:0] imm;
    } ex_content_t;

    // Address generation on a DIV-class entry runs on the ALU, not the divider.
    function automatic logic uses_div(input ex_content_t x);
        return (x.exec_unit == UNIT_DIV) && (x.mode == EX_NORMAL);
    endfunction

    function automatic logic is_squashed(input ex_content_t x, input logic fv, input spectag_t mask);
        return fv && ((x.speculative_tag & mask) != '0);
    endfunction

endpackage

// File: rtl/issue_latch_div_occupancy.sv
// Iterative divider occupancy: down-counter loaded on accept, busy until it
// reaches zero, and a one-cycle kill pulse when a flush hits the in-flight op.
module div_occupancy
    import issue_latch_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     div_accept,
    input  spectag_t div_spectag,
    input  logic     flush_valid,
    input  spectag_t flush_mask,
    output logic     div_busy,
    output logic     div_kill
);

    localparam int            CW       = $clog2(DIV_LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LATENCY - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    spectag_t      div_tag_q, div_tag_d;
    logic          div_kill_q, div_kill_d;
    logic          kill_now;

    assign div_busy = (div_cnt_q != '0);
    assign div_kill = div_kill_q;

    // Accept only happens while idle, so it can never race a kill.
    always_comb begin
        kill_now   = div_busy && flush_valid && ((div_tag_q & flush_mask) != '0);
        div_cnt_d  = div_cnt_q;
        div_tag_d  = div_tag_q;
        div_kill_d = kill_now;
        if (kill_now) begin
            div_cnt_d = '0;
        end else if (div_accept) begin
            div_cnt_d = CNT_LOAD;
            div_tag_d = div_spectag;
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            div_tag_q  <= '0;
            div_kill_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            div_tag_q  <= div_tag_d;
            div_kill_q <= div_kill_d;
        end
    end

endmodule

// File: rtl/issue_latch.sv
// Two-lane issue latch between wakeup and execution with DIV occupancy and flush squash.
// Define ISSUE_STATS_EN to add the stat_issued / stat_div_stall / stat_flushed counters.
module issue_latch
    import issue_latch_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  ex_content_t [1:0] ex_contents_in,
    input  logic              ex_stall,
    input  logic              flush_valid,
    input  spectag_t          flush_mask,
    output logic        [1:0] issued_valid,
    output tag_t        [1:0] issued_tag,
    output ex_content_t [1:0] ex_out,
    output logic              div_busy,
    output logic              div_kill
`ifdef ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_issued,
    output logic [CNT_W-1:0]  stat_div_stall,
    output logic [CNT_W-1:0]  stat_flushed
`endif
);

    if (DIV_LATENCY < 2 || CNT_W < 1) begin : g_param_check
        $error("issue_latch: DIV_LATENCY must be >= 2 and CNT_W >= 1");
    end

    ex_content_t [1:0] ex_out_q, ex_out_d;
    logic        [1:0] squash, div_op, pre_ok, div_block, accept;
    logic              div_accept;
    spectag_t          div_spectag;

    // div_block only ever applies to lanes carrying a real divider op.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            squash[i] = is_squashed(ex_contents_in[i], flush_valid, flush_mask);
            div_op[i] = ex_contents_in[i].is_valid && uses_div(ex_contents_in[i]);
            pre_ok[i] = ex_contents_in[i].is_valid && !ex_stall && !squash[i];
        end
        div_block[0] = div_op[0] && div_busy;
        div_block[1] = div_op[1] && (div_busy || (pre_ok[0] && div_op[0]));
        accept       = pre_ok & ~div_block;
        div_accept   = |(accept & div_op);
        div_spectag  = (accept[0] && div_op[0]) ? ex_contents_in[0].speculative_tag
                                                : ex_contents_in[1].speculative_tag;
    end

    always_comb begin
        ex_out_d = ex_out_q;
        for (int i = 0; i < 2; i++) begin
            if (ex_stall) begin
                if (is_squashed(ex_out_q[i], flush_valid, flush_mask)) begin
                    ex_out_d[i].is_valid = 1'b0;
                end
            end else begin
                ex_out_d[i] = accept[i] ? ex_contents_in[i] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_out_q <= '0;
        end else begin
            ex_out_q <= ex_out_d;
        end
    end

    assign issued_valid  = accept;
    assign issued_tag[0] = ex_contents_in[0].tag;
    assign issued_tag[1] = ex_contents_in[1].tag;
    assign ex_out        = ex_out_q;

    div_occupancy #(
        .DIV_LATENCY (DIV_LATENCY)
    ) u_div_occupancy (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_accept  (div_accept),
        .div_spectag (div_spectag),
        .flush_valid (flush_valid),
        .flush_mask  (flush_mask),
        .div_busy    (div_busy),
        .div_kill    (div_kill)
    );

`ifdef ISSUE_STATS_EN
    logic [CNT_W-1:0] stat_issued_q, stat_issued_d;
    logic [CNT_W-1:0] stat_div_stall_q, stat_div_stall_d;
    logic [CNT_W-1:0] stat_flushed_q, stat_flushed_d;
    logic       [1:0] in_sq, held_clr;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_sq[i]    = ex_contents_in[i].is_valid && squash[i];
            held_clr[i] = ex_stall && ex_out_q[i].is_valid
                          && is_squashed(ex_out_q[i], flush_valid, flush_mask);
        end
        stat_issued_d    = stat_issued_q + CNT_W'(accept[0]) + CNT_W'(accept[1]);
        stat_div_stall_d = stat_div_stall_q + CNT_W'(|div_block);
        stat_flushed_d   = stat_flushed_q + CNT_W'(in_sq[0]) + CNT_W'(in_sq[1])
                           + CNT_W'(held_clr[0]) + CNT_W'(held_clr[1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued_q    <= '0;
            stat_div_stall_q <= '0;
            stat_flushed_q   <= '0;
        end else begin
            stat_issued_q    <= stat_issued_d;
            stat_div_stall_q <= stat_div_stall_d;
            stat_flushed_q   <= stat_flushed_d;
        end
    end

    assign stat_issued    = stat_issued_q;
    assign stat_div_stall = stat_div_stall_q;
    assign stat_flushed   = stat_flushed_q;
`endif

endmodule

// File: tb/tb_issue_latch.sv
// Directed bench for issue_latch: per-cycle expectations go through a scoreboard queue.
module tb_issue_latch;
    import issue_latch_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    ex_content_t [1:0] ex_in;
    logic              ex_stall;
    logic              flush_valid;
    spectag_t          flush_mask;
    logic        [1:0] issued_valid;
    tag_t        [1:0] issued_tag;
    ex_content_t [1:0] ex_out;
    logic              div_busy;
    logic              div_kill;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0] ov;
        tag_t       t0;
        tag_t       t1;
        logic       busy;
        logic       kill;
    } exp_t;

    exp_t sb[$];

    localparam ex_content_t IDLE = '0;

    always #5 clk = ~clk;

    issue_latch #(
        .DIV_LATENCY (16),
        .CNT_W       (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_contents_in (ex_in),
        .ex_stall       (ex_stall),
        .flush_valid    (flush_valid),
        .flush_mask     (flush_mask),
        .issued_valid   (issued_valid),
        .issued_tag     (issued_tag),
        .ex_out         (ex_out),
        .div_busy       (div_busy),
        .div_kill       (div_kill)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    endtask

    function automatic ex_content_t mk(input tag_t t, input unit_t u, input ex_mode_t m,
                                       input spectag_t s);
        ex_content_t x;
        x.is_valid        = 1'b1;
        x.tag             = t;
        x.exec_unit       = u;
        x.mode            = m;
        x.speculative_tag = s;
        x.imm             = 32'hA000 + 32'(t);
        return x;
    endfunction

    // Drive one cycle, check the combinational issue, then check the registered result.
    task automatic cyc(input string name, input ex_content_t a, input ex_content_t b,
                       input logic st, input logic fv, input spectag_t m,
                       input logic [1:0] eiv, input logic [1:0] eov,
                       input tag_t et0, input tag_t et1, input logic eb, input logic ek);
        exp_t e;
        ex_in[0]    = a;
        ex_in[1]    = b;
        ex_stall    = st;
        flush_valid = fv;
        flush_mask  = m;
        #1;
        chk($sformatf("%s.issued_valid", name), 64'(issued_valid), 64'(eiv));
        if (eiv[0]) chk($sformatf("%s.issued_tag0", name), 64'(issued_tag[0]), 64'(a.tag));
        if (eiv[1]) chk($sformatf("%s.issued_tag1", name), 64'(issued_tag[1]), 64'(b.tag));
        e.ov   = eov;
        e.t0   = et0;
        e.t1   = et1;
        e.busy = eb;
        e.kill = ek;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("%s.ex_out_valid", name),
            64'({ex_out[1].is_valid, ex_out[0].is_valid}), 64'(e.ov));
        if (e.ov[0]) begin
            chk($sformatf("%s.ex_out0_tag", name), 64'(ex_out[0].tag), 64'(e.t0));
            chk($sformatf("%s.ex_out0_imm", name), 64'(ex_out[0].imm), 64'(32'hA000 + 32'(e.t0)));
        end
        if (e.ov[1]) begin
            chk($sformatf("%s.ex_out1_tag", name), 64'(ex_out[1].tag), 64'(e.t1));
            chk($sformatf("%s.ex_out1_imm", name), 64'(ex_out[1].imm), 64'(32'hA000 + 32'(e.t1)));
        end
        chk($sformatf("%s.div_busy", name), 64'(div_busy), 64'(e.busy));
        chk($sformatf("%s.div_kill", name), 64'(div_kill), 64'(e.kill));
    endtask

    initial begin
        ex_in       = '0;
        ex_stall    = 1'b0;
        flush_valid = 1'b0;
        flush_mask  = '0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ex_out", 64'(ex_out), 64'd0);
        chk("reset.div_busy", 64'(div_busy), 64'd0);
        chk("reset.div_kill", 64'(div_kill), 64'd0);
        rst_n = 1'b1;

        cyc("alu2", mk(5, UNIT_ALU, EX_NORMAL, 4'b0000), mk(6, UNIT_ALU, EX_NORMAL, 4'b0000),
            1'b0, 1'b0, 4'b0000, 2'b11, 2'b11, 5, 6, 1'b0, 1'b0);
        cyc("load9", mk(9, UNIT_ALU, EX_NORMAL, 4'b0000), IDLE,
            1'b0, 1'b0, 4'b0000, 2'b01, 2'b01, 9, 0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("stall%0d", k), mk(tag_t'(10 + k), UNIT_ALU, EX_NORMAL, 4'b0000),
                mk(tag_t'(20 + k), UNIT_ALU, EX_NORMAL, 4'b0000),
                1'b1, 1'b0, 4'b0000, 2'b00, 2'b01, 9, 0, 1'b0, 1'b0);
        end

        cyc("squash_in", mk(11, UNIT_ALU, EX_NORMAL, 4'b0001), mk(12, UNIT_ALU, EX_NORMAL, 4'b0100),
            1'b0, 1'b1, 4'b0100, 2'b01, 2'b01, 11, 0, 1'b0, 1'b0);
        cyc("load2", mk(13, UNIT_ALU, EX_NORMAL, 4'b0001), mk(14, UNIT_ALU, EX_NORMAL, 4'b0100),
            1'b0, 1'b0, 4'b0000, 2'b11, 2'b11, 13, 14, 1'b0, 1'b0);
        cyc("held_clear", IDLE, IDLE,
            1'b1, 1'b1, 4'b0100, 2'b00, 2'b01, 13, 0, 1'b0, 1'b0);

        cyc("div2", mk(20, UNIT_DIV, EX_NORMAL, 4'b0000), mk(21, UNIT_DIV, EX_NORMAL, 4'b0000),
            1'b0, 1'b0, 4'b0000, 2'b01, 2'b01, 20, 0, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            if (k % 2 == 1) begin
                cyc($sformatf("div_busy%0d", k), mk(30, UNIT_ALU, EX_NORMAL, 4'b0000),
                    mk(31, UNIT_DIV, EX_NORMAL, 4'b0000),
                    1'b0, 1'b0, 4'b0000, 2'b01, 2'b01, 30, 0, (k < 15), 1'b0);
            end else begin
                cyc($sformatf("div_busy%0d", k), mk(32, UNIT_DIV, EX_NORMAL, 4'b0000),
                    mk(33, UNIT_ALU, EX_NORMAL, 4'b0000),
                    1'b0, 1'b0, 4'b0000, 2'b10, 2'b10, 0, 33, (k < 15), 1'b0);
            end
        end
        cyc("div_free", IDLE, mk(22, UNIT_DIV, EX_NORMAL, 4'b0010),
            1'b0, 1'b0, 4'b0000, 2'b10, 2'b10, 0, 22, 1'b1, 1'b0);

        cyc("div_flush", mk(40, UNIT_DIV, EX_GEN_ADDR, 4'b0000), mk(41, UNIT_ALU, EX_NORMAL, 4'b0010),
            1'b0, 1'b1, 4'b0010, 2'b01, 2'b01, 40, 0, 1'b0, 1'b1);
        cyc("kill_end", IDLE, IDLE,
            1'b0, 1'b0, 4'b0000, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        cyc("div_again", mk(42, UNIT_DIV, EX_NORMAL, 4'b0001), IDLE,
            1'b0, 1'b0, 4'b0000, 2'b01, 2'b01, 42, 0, 1'b1, 1'b0);

        // Reset lands while a DIV is in flight and a matching flush is presented.
        ex_in[0]    = mk(44, UNIT_ALU, EX_NORMAL, 4'b0001);
        ex_in[1]    = IDLE;
        flush_valid = 1'b1;
        flush_mask  = 4'b0001;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.ex_out", 64'(ex_out), 64'd0);
        chk("rst_mid.div_busy", 64'(div_busy), 64'd0);
        chk("rst_mid.div_kill", 64'(div_kill), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold.div_kill", 64'(div_kill), 64'd0);
        chk("rst_hold.ex_out", 64'(ex_out), 64'd0);
        rst_n       = 1'b1;
        flush_valid = 1'b0;

        cyc("post_rst", mk(43, UNIT_DIV, EX_NORMAL, 4'b0000), IDLE,
            1'b0, 1'b0, 4'b0000, 2'b01, 2'b01, 43, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
